// File: rtl/genius_sprite_pkg.sv
// Sprite identifiers and dimension table shared by the sprite fetch logic.
// Every sprite has an even pixel count, so pixels always pair into whole ROM words.
package genius_sprite_pkg;

  localparam logic [2:0] SPR_BACKGROUND = 3'd0;
  localparam logic [2:0] SPR_POWER_BTN  = 3'd1;
  localparam logic [2:0] SPR_RED        = 3'd2;
  localparam logic [2:0] SPR_GREEN      = 3'd3;
  localparam logic [2:0] SPR_BLUE       = 3'd4;
  localparam logic [2:0] SPR_YELLOW     = 3'd5;
  localparam logic [2:0] SPR_WIN        = 3'd6;
  localparam logic [2:0] SPR_LOSE       = 3'd7;

  typedef struct packed {
    logic [8:0] w;
    logic [8:0] h;
  } sprite_dim_t;

  function automatic sprite_dim_t sprite_dims(input logic [2:0] id);
    sprite_dim_t d;
    case (id)
      SPR_BACKGROUND: d = '{w: 9'd360, h: 9'd360};
      SPR_POWER_BTN:  d = '{w: 9'd22,  h: 9'd21};
      SPR_RED:        d = '{w: 9'd169, h: 9'd168};
      SPR_GREEN:      d = '{w: 9'd168, h: 9'd168};
      SPR_BLUE:       d = '{w: 9'd168, h: 9'd167};
      SPR_YELLOW:     d = '{w: 9'd168, h: 9'd167};
      SPR_WIN:        d = '{w: 9'd360, h: 9'd116};
      default:        d = '{w: 9'd360, h: 9'd134};
    endcase
    return d;
  endfunction

  function automatic logic [15:0] word_count(input logic [2:0] id);
    sprite_dim_t d;
    logic [17:0] px;
    d  = sprite_dims(id);
    px = 18'(d.w) * 18'(d.h);
    return 16'(px >> 1);
  endfunction

endpackage

// File: rtl/sprite_reader.sv
// Fetches a sprite from ROM one 16-bit word at a time and streams its pixels,
// high byte first, with screen coordinates over a valid/ready handshake.
//
// state    | meaning
// IDLE     | waiting for START; selector/rom address hold last sprite
// ADDR     | present current word address to ROM, load latency timer
// WAIT     | latency timer counting down; capture ROM word on expiry
// EMIT_HI  | offer high-byte pixel
// EMIT_LO  | offer low-byte pixel; last pixel ends the sprite
// FINISH   | one-cycle DONE pulse
module sprite_reader
  import genius_sprite_pkg::*;
#(
  parameter int ROM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  SPRITE_ID,
  input  logic [8:0]  ORIGIN_X,
  input  logic [8:0]  ORIGIN_Y,
  output logic [2:0]  SELECTOR,
  output logic [15:0] ROM_ADDR,
  input  logic [15:0] ROM_PX,
  output logic        PX_VALID,
  input  logic        PX_READY,
  output logic [7:0]  PX_DATA,
  output logic [8:0]  PX_X,
  output logic [8:0]  PX_Y,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_EMIT_HI = 3'd3;
  localparam logic [2:0] S_EMIT_LO = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [7:0] LAT_LOAD = 8'(ROM_LATENCY);

  logic [2:0]  state;
  logic [2:0]  sel_q;
  logic [8:0]  ox_q, oy_q, w_q, h_q;
  logic [8:0]  col, row;
  logic [15:0] word_addr, rom_addr_q, word_q;
  logic [7:0]  lat_cnt;

  sprite_dim_t start_dim;
  logic        px_valid, hs, col_last, px_last;

  assign start_dim = sprite_dims(SPRITE_ID);
  assign px_valid  = (state == S_EMIT_HI) || (state == S_EMIT_LO);
  assign hs        = px_valid && PX_READY;
  assign col_last  = (col == w_q - 9'd1);
  assign px_last   = col_last && (row == h_q - 9'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      sel_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col        <= '0;
      row        <= '0;
      word_addr  <= '0;
      rom_addr_q <= '0;
      word_q     <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            sel_q     <= SPRITE_ID;
            ox_q      <= ORIGIN_X;
            oy_q      <= ORIGIN_Y;
            w_q       <= start_dim.w;
            h_q       <= start_dim.h;
            word_addr <= '0;
            col       <= '0;
            row       <= '0;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          rom_addr_q <= word_addr;
          lat_cnt    <= LAT_LOAD;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // Capture one cycle after the timer reaches zero so a ROM with
          // exactly ROM_LATENCY register stages has settled.
          if (lat_cnt == 8'd0) begin
            word_q <= ROM_PX;
            state  <= S_EMIT_HI;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        S_EMIT_HI: begin
          if (PX_READY) state <= S_EMIT_LO;
        end
        S_EMIT_LO: begin
          if (PX_READY) begin
            if (px_last) begin
              state <= S_FINISH;
            end else begin
              word_addr <= word_addr + 16'd1;
              state     <= S_ADDR;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      // Row wrap may fall between the two pixels of a single word.
      if (hs) begin
        if (col_last) begin
          col <= '0;
          row <= row + 9'd1;
        end else begin
          col <= col + 9'd1;
        end
      end
    end
  end

  assign PX_VALID = px_valid;
  assign PX_DATA  = (state == S_EMIT_HI) ? word_q[15:8] :
                    (state == S_EMIT_LO) ? word_q[7:0]  : 8'd0;
  assign PX_X     = px_valid ? (ox_q + col) : 9'd0;
  assign PX_Y     = px_valid ? (oy_q + row) : 9'd0;
  assign BUSY     = (state != S_IDLE);
  assign DONE     = (state == S_FINISH);
  assign SELECTOR = sel_q;
  assign ROM_ADDR = rom_addr_q;

endmodule

// File: tb/tb_sprite_reader.sv
// Scoreboard bench for sprite_reader: a ROM returning word=address, a pixel
// model built from sprite dimensions, and a monitor checking every handshake.
module tb_sprite_reader;

  localparam int ROM_LAT = 2;

  typedef struct {
    logic [7:0] d;
    logic [8:0] x;
    logic [8:0] y;
    bit         last;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  SPRITE_ID = '0;
  logic [8:0]  ORIGIN_X = '0;
  logic [8:0]  ORIGIN_Y = '0;
  logic [2:0]  SELECTOR;
  logic [15:0] ROM_ADDR;
  logic [15:0] ROM_PX;
  logic        PX_VALID;
  logic        PX_READY = 1'b1;
  logic [7:0]  PX_DATA;
  logic [8:0]  PX_X, PX_Y;
  logic        BUSY, DONE;

  int tests = 0;
  int fails = 0;

  int tw[8] = '{360, 22, 169, 168, 168, 168, 360, 360};
  int th[8] = '{360, 21, 168, 168, 167, 167, 116, 134};

  exp_t sb[$];
  bit   rand_ready = 1'b0;
  int   done_cnt = 0;
  int   run_idx = 0;
  int   obs_d[512], obs_x[512], obs_y[512], obs_a[512];

  sprite_reader #(.ROM_LATENCY(ROM_LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SPRITE_ID(SPRITE_ID),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .SELECTOR(SELECTOR),
    .ROM_ADDR(ROM_ADDR), .ROM_PX(ROM_PX), .PX_VALID(PX_VALID),
    .PX_READY(PX_READY), .PX_DATA(PX_DATA), .PX_X(PX_X), .PX_Y(PX_Y),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // ROM model: ROM_LAT register stages, word content equals its address.
  logic [15:0] rom_pipe [ROM_LAT];
  always @(posedge CLK) begin
    rom_pipe[0] <= ROM_ADDR;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign ROM_PX = rom_pipe[ROM_LAT-1];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      PX_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stalls and DONE timing.
  bit         stall_prev = 0, expect_done = 0, busy_prev = 0;
  logic [7:0] hold_d;
  logic [8:0] hold_x, hold_y;
  exp_t       mon_e;
  initial begin
    forever begin
      @(negedge CLK);
      if (stall_prev) begin
        check("stall_valid", int'(PX_VALID), 1);
        check("stall_data", int'(PX_DATA), int'(hold_d));
        check("stall_x", int'(PX_X), int'(hold_x));
        check("stall_y", int'(PX_Y), int'(hold_y));
      end
      if (DONE || expect_done) check("done_timing", int'(DONE), int'(expect_done));
      if (DONE) done_cnt++;
      expect_done = 0;
      if (BUSY && !busy_prev) run_idx = 0;
      if (PX_VALID && PX_READY) begin
        check("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("px_data", int'(PX_DATA), int'(mon_e.d));
          check("px_x", int'(PX_X), int'(mon_e.x));
          check("px_y", int'(PX_Y), int'(mon_e.y));
          if (mon_e.last) expect_done = 1;
        end
        if (run_idx < 512) begin
          obs_d[run_idx] = int'(PX_DATA);
          obs_x[run_idx] = int'(PX_X);
          obs_y[run_idx] = int'(PX_Y);
          obs_a[run_idx] = int'(ROM_ADDR);
        end
        run_idx++;
      end
      stall_prev = PX_VALID && !PX_READY;
      hold_d = PX_DATA;
      hold_x = PX_X;
      hold_y = PX_Y;
      busy_prev = BUSY;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_done"}, int'(DONE), 0);
    check({tag, "_valid"}, int'(PX_VALID), 0);
    check({tag, "_data"}, int'(PX_DATA), 0);
    check({tag, "_x"}, int'(PX_X), 0);
    check({tag, "_y"}, int'(PX_Y), 0);
    check({tag, "_sel"}, int'(SELECTOR), 0);
    check({tag, "_addr"}, int'(ROM_ADDR), 0);
  endtask

  // abort_at < 0 runs to completion; poke pulses START mid-run and in FINISH.
  task automatic run_sprite(input int id, input int ox, input int oy,
                            input int abort_at, input bit rnd, input bit poke);
    int w, h, total, n_push, hs, cyc;
    bit fin, aborted;
    logic [15:0] word;
    exp_t e;
    w = tw[id];
    h = th[id];
    total = w * h;
    n_push = (abort_at >= 0) ? abort_at + 1 : total;
    for (int p = 0; p < n_push; p++) begin
      word   = 16'(p / 2);
      e.d    = (p % 2 == 1) ? word[7:0] : word[15:8];
      e.x    = 9'((ox + p % w) % 512);
      e.y    = 9'((oy + p / w) % 512);
      e.last = (p == total - 1);
      sb.push_back(e);
    end
    rand_ready = rnd;
    @(negedge CLK);
    SPRITE_ID = 3'(id);
    ORIGIN_X  = 9'(ox);
    ORIGIN_Y  = 9'(oy);
    START     = 1'b1;
    hs = 0; cyc = 0; fin = 0; aborted = 0;
    while (!fin && cyc < 20000) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      if (PX_VALID && PX_READY) begin
        if (hs == abort_at) begin
          RST = 1'b1;
          fin = 1;
          aborted = 1;
        end
        if (poke && hs == 50) begin
          START = 1'b1;
          SPRITE_ID = 3'd5;
        end
        hs++;
      end
      if (DONE) begin
        fin = 1;
        if (poke) begin
          START = 1'b1;
          SPRITE_ID = 3'd6;
        end
      end
    end
    check("run_finished", int'(fin), 1);
    rand_ready = 1'b0;
    if (aborted) begin
      @(negedge CLK);
      check_all_zero("abort");
      check("abort_sb_empty", sb.size(), 0);
      RST = 1'b0;
    end else begin
      check("last_rom_addr", int'(ROM_ADDR), total / 2 - 1);
      check("sel_at_done", int'(SELECTOR), id);
      @(negedge CLK);
      START = 1'b0;
      check("idle_busy", int'(BUSY), 0);
      check("idle_done", int'(DONE), 0);
      check("idle_sel", int'(SELECTOR), id);
      @(negedge CLK);
      check("idle_busy2", int'(BUSY), 0);
    end
  endtask

  int done_before;

  initial begin
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // POWER_BTN at (10,20), always ready
    done_before = done_cnt;
    run_sprite(1, 10, 20, -1, 0, 0);
    check("done_count_a", done_cnt - done_before, 1);
    check("p0_x", obs_x[0], 10);
    check("p0_y", obs_y[0], 20);
    check("p0_d", obs_d[0], 0);
    check("p3_x", obs_x[3], 13);
    check("p3_d", obs_d[3], 1);
    check("plast_x", obs_x[461], 31);
    check("plast_y", obs_y[461], 40);

    // Same sprite with random back-pressure
    done_before = done_cnt;
    run_sprite(1, 10, 20, -1, 1, 0);
    check("done_count_b", done_cnt - done_before, 1);

    // START while busy and during FINISH must be ignored
    done_before = done_cnt;
    run_sprite(1, 10, 20, -1, 1, 1);
    check("done_count_c", done_cnt - done_before, 1);

    // RED: row wrap between the two pixels of word 84
    run_sprite(2, 0, 0, 200, 0, 0);
    check("w84_hi_x", obs_x[168], 168);
    check("w84_hi_y", obs_y[168], 0);
    check("w84_hi_d", obs_d[168], 0);
    check("w84_lo_x", obs_x[169], 0);
    check("w84_lo_y", obs_y[169], 1);
    check("w84_lo_d", obs_d[169], 84);

    // Reset on pixel 100 handshake, then restart from word 0
    done_before = done_cnt;
    run_sprite(1, 10, 20, 100, 0, 0);
    check("abort_no_done", done_cnt - done_before, 0);
    done_before = done_cnt;
    run_sprite(1, 10, 20, -1, 0, 0);
    check("restart_addr0", obs_a[0], 0);
    check("restart_done", done_cnt - done_before, 1);

    // BACKGROUND at x=300: column 300 wraps to 88
    run_sprite(0, 300, 0, 310, 1, 0);
    check("wrap_x300", obs_x[300], 88);
    check("wrap_x211", obs_x[211], 511);
    check("wrap_x212", obs_x[212], 0);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sprite_reader.md
SPRITE_READER -- requirements
Module: sprite_reader

Interface
REQ-001 The block SHALL have parameter ROM_LATENCY, default 2, giving the cycles from a ROM_ADDR change to valid ROM_PX.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock.
REQ-003 The block SHALL have port RST, input, 1 bit, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit, a request pulse.
REQ-005 The block SHALL have port SPRITE_ID, input, 3 bits: 0 BACKGROUND, 1 POWER_BTN, 2 RED, 3 GREEN, 4 BLUE, 5 YELLOW, 6 WIN, 7 LOSE.
REQ-006 The block SHALL have ports ORIGIN_X and ORIGIN_Y, input, 9 bits each, the screen position of the sprite's top-left pixel.
REQ-007 The block SHALL have ports SELECTOR (output, 3 bits) and ROM_ADDR (output, 16 bits), which drive the memory demultiplexer.
REQ-008 The block SHALL have port ROM_PX, input, 16 bits, the returned word; each word holds two 8-bit pixels, high byte first.
REQ-009 The block SHALL have port PX_VALID, output, 1 bit, and port PX_READY, input, 1 bit, forming the pixel-stream handshake.
REQ-010 The block SHALL have ports PX_DATA (output, 8 bits), PX_X (output, 9 bits) and PX_Y (output, 9 bits).
REQ-011 The block SHALL have port BUSY, output, 1 bit, and port DONE, output, 1 bit, a single-cycle pulse.

Function
REQ-012 The FSM SHALL have the states IDLE, ADDR, WAIT, EMIT_HI, EMIT_LO and FINISH.
REQ-013 In IDLE, a START pulse SHALL latch SPRITE_ID, the origin, and width W and height H from the package table; it SHALL clear the word address, column and row, and move the FSM to ADDR.
REQ-014 START SHALL be ignored in every state except IDLE.
REQ-015 ADDR SHALL register ROM_ADDR to the current word address, load a latency counter with ROM_LATENCY, and move to WAIT.
REQ-016 WAIT SHALL count down the latency counter; when it expires, the block SHALL capture ROM_PX into a word register and move to EMIT_HI.
REQ-017 EMIT_HI and EMIT_LO SHALL assert PX_VALID, with PX_DATA set to word[15:8] or word[7:0] respectively, PX_X = (ORIGIN_X+col) mod 512, and PX_Y = (ORIGIN_Y+row) mod 512.
REQ-018 PX_DATA, PX_X and PX_Y SHALL stay stable while PX_VALID is high and PX_READY is low.
REQ-019 A handshake (PX_VALID and PX_READY both high) SHALL advance col; when col reaches W-1 it SHALL wrap to 0 and increment row, including between the HI and LO pixels of one word.
REQ-020 A handshake in EMIT_LO on pixel index W*H-1 SHALL move the FSM to FINISH; any other EMIT_LO handshake SHALL increment the word address and move to ADDR.
REQ-021 FINISH SHALL pulse DONE for exactly one cycle and return the FSM to IDLE.
REQ-022 BUSY SHALL be high in every state except IDLE.
REQ-023 SELECTOR SHALL equal the latched SPRITE_ID and SHALL hold that value after FINISH until the next accepted START.
REQ-024 ROM_ADDR SHALL change only in ADDR.
REQ-025 The last word address SHALL be W*H/2-1, and W*H SHALL be even for every sprite.

Reset
REQ-026 Under RST, the FSM SHALL enter IDLE, and BUSY, DONE, PX_VALID, PX_DATA, PX_X, PX_Y, SELECTOR, ROM_ADDR and all counters SHALL be 0 on the next cycle.
REQ-027 RST asserted mid-sprite SHALL abort the transfer without a DONE pulse.

Structure
REQ-028 A shared package genius_sprite_pkg SHALL hold the sprite ID constants and the W/H table: 360x360, 22x21, 169x168, 168x168, 168x167, 168x167, 360x116, 360x134.
REQ-029 The package SHALL also hold a word-count function returning W*H/2.
REQ-030 The block SHALL use no sub-module; the dimension lookup SHALL be the package function.

Verification
REQ-031 START with ID 1, origin (10,20), PX_READY=1, ROM model returning word=address -> 462 pixels; first pixel (10,20) data 00; pixel 3 (13,20) data 01; last pixel (31,40); final ROM_ADDR 230; exactly one DONE, the cycle after the final handshake.
REQ-032 ID 2 (W=169), origin (0,0) -> word 84 yields pixel 168 at (168,0) and pixel 169 at (0,1).
REQ-033 The REQ-031 stimulus with PX_READY random at 50% -> an identical pixel/coordinate sequence, with outputs stable across every stall.
REQ-034 START pulsed while BUSY, and in the FINISH cycle -> ignored, SELECTOR unchanged, exactly one DONE.
REQ-035 RST on the handshake of pixel 100 -> all outputs 0 next cycle, no DONE; a new START restarts at ROM_ADDR 0.
REQ-036 ID 0, origin (300,0) -> the pixel at col 300 reports PX_X=88.
